// File: rtl/axis_packet_capture_if.sv
// AXI-Stream bus bundle shared by the packet source and the capture block.
//   tdata  : DATA_BYTES lanes of 8 bits, lane i at tdata[8i+:8]
//   tkeep  : per-lane byte qualifier
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a packet
//   tuser  : sideband, meaningful on the first beat
interface AXIS_int #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_packet_capture.sv
// Captures one AXI-Stream packet into a flat byte buffer and holds it for a consumer.
//   clk, sreset          : clock, synchronous active-high reset
//   axis_packet_in       : AXIS slave input (one packet at a time)
//   packet_valid/ack     : presented packet and consumer release
//   packet_data          : byte k at bits [8k:8k+7], bytes at/after length read 0
//   packet_byte_length   : stored bytes, saturating at MTU_BYTES
//   packet_user          : tuser of the first beat
//   packet_truncated     : packet was longer than MTU_BYTES
//   packet_keep_error    : malformed tkeep seen in the packet
//   busy                 : packet in progress or held
//   packet_count         : acknowledged packets, wrapping
module axis_packet_capture #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned MTU_BYTES  = 1500
) (
    input  logic                             clk,
    input  logic                             sreset,
    AXIS_int.slave                           axis_packet_in,
    output logic                             packet_valid,
    input  logic                             packet_ack,
    output logic [0:MTU_BYTES*8-1]           packet_data,
    output logic [$clog2(MTU_BYTES+1)-1:0]   packet_byte_length,
    output logic [USER_WIDTH-1:0]            packet_user,
    output logic                             packet_truncated,
    output logic                             packet_keep_error,
    output logic                             busy,
    output logic [31:0]                      packet_count
);
    localparam int unsigned LEN_W = $clog2(MTU_BYTES + 1);
    localparam int unsigned OFF_W = LEN_W + 1;  // headroom so offset+popcount cannot wrap
    localparam int unsigned POP_W = $clog2(DATA_BYTES + 1);

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    if (MTU_BYTES < DATA_BYTES) begin : g_bad_mtu
        $error("axis_packet_capture: MTU_BYTES must be >= DATA_BYTES");
    end

    logic [0:0]              state_q, state_d;
    logic                    tready_q;
    logic                    in_pkt_q;
    logic [OFF_W-1:0]        wr_off_q;
    logic [MTU_BYTES*8-1:0]  buf_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic                    trunc_q;
    logic                    kerr_q;
    logic [31:0]             count_q;

    logic                    beat_fire;
    logic [POP_W-1:0]        keep_pop;
    logic                    keep_bad;
    logic [OFF_W-1:0]        off_sum;
    logic                    over;
    logic [OFF_W-1:0]        off_next;
    logic [OFF_W-1:0]        lane_idx [DATA_BYTES];
    logic [DATA_BYTES-1:0]   lane_we;

    // Beat decode: popcount, keep legality, saturating offset and per-lane write targets
    always_comb begin
        beat_fire = axis_packet_in.tvalid && tready_q;
        keep_pop  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            keep_pop = keep_pop + POP_W'(axis_packet_in.tkeep[i]);
        end
        // low-contiguous means adding one clears every set bit
        keep_bad = (axis_packet_in.tkeep == '0)
                || ((axis_packet_in.tkeep & (axis_packet_in.tkeep + DATA_BYTES'(1))) != '0)
                || (!axis_packet_in.tlast && (axis_packet_in.tkeep != '1));
        off_sum  = wr_off_q + OFF_W'(keep_pop);
        over     = off_sum > OFF_W'(MTU_BYTES);
        off_next = over ? OFF_W'(MTU_BYTES) : off_sum;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_idx[i] = wr_off_q + OFF_W'(i);
            lane_we[i]  = beat_fire && axis_packet_in.tkeep[i]
                       && (lane_idx[i] < OFF_W'(MTU_BYTES));
        end
    end

    // Next-state: finish on the tlast beat, release on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RECV: if (beat_fire && axis_packet_in.tlast) state_d = ST_HOLD;
            ST_HOLD: if (packet_ack)                        state_d = ST_RECV;
            default: state_d = ST_RECV;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (sreset) state_q <= ST_RECV;
        else        state_q <= state_d;
    end

    // Buffer, offset, flags, counter and registered tready
    always_ff @(posedge clk) begin
        if (sreset) begin
            tready_q <= 1'b0;
            in_pkt_q <= 1'b0;
            wr_off_q <= '0;
            buf_q    <= '0;
            user_q   <= '0;
            trunc_q  <= 1'b0;
            kerr_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            tready_q <= (state_d == ST_RECV);
            if ((state_q == ST_HOLD) && packet_ack) begin
                wr_off_q <= '0;
                buf_q    <= '0;
                user_q   <= '0;
                trunc_q  <= 1'b0;
                kerr_q   <= 1'b0;
                count_q  <= count_q + 32'd1;
            end else if (beat_fire) begin
                for (int i = 0; i < DATA_BYTES; i++) begin
                    if (lane_we[i]) buf_q[8*lane_idx[i] +: 8] <= axis_packet_in.tdata[8*i +: 8];
                end
                wr_off_q <= off_next;
                if (over)      trunc_q <= 1'b1;
                if (keep_bad)  kerr_q  <= 1'b1;
                if (!in_pkt_q) user_q  <= axis_packet_in.tuser;
                in_pkt_q <= !axis_packet_in.tlast;
            end
        end
    end

    // Bytes past the length are masked so stray lanes from a gapped tkeep never show
    for (genvar k = 0; k < MTU_BYTES; k++) begin : g_out
        assign packet_data[8*k +: 8] = (OFF_W'(k) < wr_off_q) ? buf_q[8*k +: 8] : 8'h00;
    end

    assign axis_packet_in.tready = tready_q;
    assign packet_valid          = (state_q == ST_HOLD);
    assign busy                  = in_pkt_q | (state_q == ST_HOLD);
    assign packet_byte_length    = LEN_W'(wr_off_q);
    assign packet_user           = user_q;
    assign packet_truncated      = trunc_q;
    assign packet_keep_error     = kerr_q;
    assign packet_count          = count_q;
endmodule

// File: tb/tb_axis_packet_capture.sv
// Directed bench for axis_packet_capture with DATA_BYTES=8, MTU_BYTES=1500.
module tb_axis_packet_capture;
    localparam int unsigned DB  = 8;
    localparam int unsigned UW  = 1;
    localparam int unsigned MTU = 1500;
    localparam int unsigned LW  = $clog2(MTU + 1);

    logic                clk = 1'b0;
    logic                sreset;
    logic                packet_valid;
    logic                packet_ack;
    logic [0:MTU*8-1]    packet_data;
    logic [LW-1:0]       packet_byte_length;
    logic [UW-1:0]       packet_user;
    logic                packet_truncated;
    logic                packet_keep_error;
    logic                busy;
    logic [31:0]         packet_count;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int exp_cnt = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    AXIS_int #(.DATA_BYTES(DB), .USER_WIDTH(UW)) axis ();

    axis_packet_capture #(.DATA_BYTES(DB), .USER_WIDTH(UW), .MTU_BYTES(MTU)) dut (
        .clk                (clk),
        .sreset             (sreset),
        .axis_packet_in     (axis),
        .packet_valid       (packet_valid),
        .packet_ack         (packet_ack),
        .packet_data        (packet_data),
        .packet_byte_length (packet_byte_length),
        .packet_user        (packet_user),
        .packet_truncated   (packet_truncated),
        .packet_keep_error  (packet_keep_error),
        .busy               (busy),
        .packet_count       (packet_count)
    );

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'(seed * 37 + k * 3 + 1);
    endfunction

    function automatic logic [7:0] dbyte(input int k);
        return packet_data[8*k +: 8];
    endfunction

    // Drive one beat from the negedge, wait for tready, record kept lanes once accepted
    task automatic send_beat(input int seed, input int beat, input logic [7:0] keep,
                             input logic last, input logic user);
        int waited;
        waited = 0;
        @(negedge clk);
        for (int i = 0; i < DB; i++) axis.tdata[8*i +: 8] = pat(seed, beat*8 + i);
        axis.tkeep  = keep;
        axis.tlast  = last;
        axis.tuser  = user;
        axis.tvalid = 1'b1;
        while (axis.tready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
            stalls++;
        end
        if (waited >= 300) begin
            checks++; errors++;
            $display("FAIL beat_timeout seed=%0d beat=%0d tready=%b required 1", seed, beat, axis.tready);
        end else begin
            @(posedge clk);
            for (int i = 0; i < DB; i++) if (keep[i]) exp_q.push_back(pat(seed, beat*8 + i));
        end
    endtask

    task automatic send_pkt(input int seed, input int nbeats, input logic [7:0] last_keep,
                            input logic user);
        for (int b = 0; b < nbeats; b++)
            send_beat(seed, b, (b == nbeats-1) ? last_keep : 8'hFF, b == nbeats-1,
                      (b == 0) ? user : ~user);
        #1 axis.tvalid = 1'b0;
    endtask

    task automatic check_data(input string name, input int len);
        int bad;
        int first;
        logic [7:0] e;
        logic [7:0] fa;
        logic [7:0] fe;
        bad = 0; first = -1; fa = 0; fe = 0;
        for (int k = 0; k < MTU; k++) begin
            e = (k < len) ? exp_q[k] : 8'h00;
            if (dbyte(k) !== e) begin
                if (bad == 0) begin first = k; fa = dbyte(k); fe = e; end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_data bad_bytes=%0d first=%0d got=%h required %h", name, bad, first, fa, fe);
        end
    endtask

    task automatic do_ack(input string name);
        exp_q.delete();
        @(negedge clk) packet_ack = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        checks++;
        if (packet_valid !== 1'b0 || axis.tready !== 1'b1 || packet_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_ack valid=%b tready=%b count=%0d required 0 1 %0d",
                     name, packet_valid, axis.tready, packet_count, exp_cnt);
        end
        @(negedge clk) packet_ack = 1'b0;
    endtask

    task automatic test_reset;
        sreset = 1'b1; packet_ack = 1'b0;
        axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tkeep = '0; axis.tdata = '0; axis.tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (axis.tready !== 1'b0 || packet_valid !== 1'b0 || packet_byte_length !== '0 ||
            packet_count !== '0 || busy !== 1'b0 || packet_user !== '0 ||
            packet_truncated !== 1'b0 || packet_keep_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs tready=%b valid=%b len=%0d count=%0d busy=%b user=%b tr=%b ke=%b required all 0",
                     axis.tready, packet_valid, packet_byte_length, packet_count, busy,
                     packet_user, packet_truncated, packet_keep_error);
        end
        checks++;
        if (packet_data !== '0) begin
            errors++;
            $display("FAIL reset_data byte0=%h required 00", dbyte(0));
        end
        @(negedge clk) sreset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready got=%b required 1", axis.tready);
        end
        // ack outside HOLD must do nothing
        @(negedge clk) packet_ack = 1'b1;
        @(negedge clk) packet_ack = 1'b0;
        checks++;
        if (packet_count !== 32'd0 || packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack count=%0d valid=%b required 0 0", packet_count, packet_valid);
        end
    endtask

    task automatic test_single;
        send_pkt(1, 8, 8'hFF, 1'b0);
        checks++;
        if (packet_valid !== 1'b1 || axis.tready !== 1'b0 || packet_byte_length !== LW'(64) ||
            packet_user !== 1'b0 || packet_truncated !== 1'b0 || packet_keep_error !== 1'b0 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL single_status valid=%b tready=%b len=%0d user=%b tr=%b ke=%b busy=%b required 1 0 64 0 0 0 1",
                     packet_valid, axis.tready, packet_byte_length, packet_user,
                     packet_truncated, packet_keep_error, busy);
        end
        check_data("single", 64);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== LW'(64) || dbyte(63) !== pat(1, 63)) begin
            errors++;
            $display("FAIL single_hold valid=%b len=%0d byte63=%h required 1 64 %h",
                     packet_valid, packet_byte_length, dbyte(63), pat(1, 63));
        end
        do_ack("single");
    endtask

    task automatic test_partial;
        send_pkt(2, 8, 8'h1F, 1'b1);
        checks++;
        if (packet_byte_length !== LW'(61) || packet_truncated !== 1'b0 ||
            packet_keep_error !== 1'b0 || packet_user !== 1'b1) begin
            errors++;
            $display("FAIL partial_status len=%0d tr=%b ke=%b user=%b required 61 0 0 1",
                     packet_byte_length, packet_truncated, packet_keep_error, packet_user);
        end
        checks++;
        if (dbyte(60) !== pat(2, 7*8 + 4) || dbyte(61) !== 8'h00) begin
            errors++;
            $display("FAIL partial_tail byte60=%h byte61=%h required %h 00", dbyte(60), dbyte(61), pat(2, 60));
        end
        check_data("partial", 61);
        do_ack("partial");
    endtask

    task automatic test_oversize;
        stalls = 0;
        send_pkt(3, 188, 8'hFF, 1'b0);
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL oversize_stall stall_cycles=%0d required 0", stalls);
        end
        checks++;
        if (packet_byte_length !== LW'(1500) || packet_truncated !== 1'b1 || packet_keep_error !== 1'b0) begin
            errors++;
            $display("FAIL oversize_status len=%0d tr=%b ke=%b required 1500 1 0",
                     packet_byte_length, packet_truncated, packet_keep_error);
        end
        check_data("oversize", 1500);
        do_ack("oversize");
    endtask

    task automatic test_keep_error;
        send_beat(4, 0, 8'hFF, 1'b0, 1'b0);
        send_beat(4, 1, 8'h0F, 1'b0, 1'b0);
        send_beat(4, 2, 8'hFF, 1'b1, 1'b0);
        #1 axis.tvalid = 1'b0;
        checks++;
        if (packet_keep_error !== 1'b1 || packet_byte_length !== LW'(20)) begin
            errors++;
            $display("FAIL keep_err_status ke=%b len=%0d required 1 20", packet_keep_error, packet_byte_length);
        end
        check_data("keep_err", 20);
        do_ack("keep_err");
        send_pkt(5, 2, 8'hFF, 1'b0);
        checks++;
        if (packet_keep_error !== 1'b0 || packet_byte_length !== LW'(16)) begin
            errors++;
            $display("FAIL keep_clean ke=%b len=%0d required 0 16", packet_keep_error, packet_byte_length);
        end
        do_ack("keep_clean");
        send_pkt(6, 1, 8'h00, 1'b0);
        checks++;
        if (packet_valid !== 1'b1 || packet_keep_error !== 1'b1 || packet_byte_length !== LW'(0)) begin
            errors++;
            $display("FAIL keep_zero_last valid=%b ke=%b len=%0d required 1 1 0",
                     packet_valid, packet_keep_error, packet_byte_length);
        end
        do_ack("keep_zero");
    endtask

    task automatic test_back_to_back;
        for (int b = 0; b < 4; b++) send_beat(7, b, 8'hFF, b == 3, 1'b0);
        fork
            begin
                for (int b = 0; b < 3; b++) send_beat(8, b, 8'hFF, b == 2, 1'b0);
                #1 axis.tvalid = 1'b0;
            end
            begin
                int high;
                high = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (axis.tready !== 1'b0) high++;
                end
                checks++;
                if (high != 0) begin
                    errors++;
                    $display("FAIL b2b_hold_ready cycles_ready=%0d required 0", high);
                end
                checks++;
                if (packet_valid !== 1'b1 || packet_byte_length !== LW'(32)) begin
                    errors++;
                    $display("FAIL b2b_first valid=%b len=%0d required 1 32", packet_valid, packet_byte_length);
                end
                check_data("b2b_first", 32);
                exp_q.delete();
                packet_ack = 1'b1;
                @(posedge clk);
                #1;
                exp_cnt++;
                checks++;
                if (packet_valid !== 1'b0 || axis.tready !== 1'b1 || packet_count !== 32'(exp_cnt)) begin
                    errors++;
                    $display("FAIL b2b_ack valid=%b tready=%b count=%0d required 0 1 %0d",
                             packet_valid, axis.tready, packet_count, exp_cnt);
                end
                @(negedge clk) packet_ack = 1'b0;
            end
        join
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== LW'(24)) begin
            errors++;
            $display("FAIL b2b_second valid=%b len=%0d required 1 24", packet_valid, packet_byte_length);
        end
        check_data("b2b_second", 24);
        do_ack("b2b_second");
    endtask

    task automatic test_reset_mid;
        for (int b = 0; b < 3; b++) send_beat(9, b, 8'hFF, 1'b0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b1 || packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy busy=%b valid=%b required 1 0", busy, packet_valid);
        end
        @(negedge clk);
        axis.tvalid = 1'b0;
        sreset = 1'b1;
        @(negedge clk) sreset = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        checks++;
        if (packet_valid !== 1'b0 || packet_count !== 32'd0 || busy !== 1'b0 || packet_byte_length !== '0) begin
            errors++;
            $display("FAIL mid_reset valid=%b count=%0d busy=%b len=%0d required 0 0 0 0",
                     packet_valid, packet_count, busy, packet_byte_length);
        end
        for (int b = 3; b < 10; b++) send_beat(9, b, 8'hFF, b == 9, 1'b0);
        #1 axis.tvalid = 1'b0;
        checks++;
        if (packet_valid !== 1'b1 || packet_byte_length !== LW'(56) || packet_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_new_pkt valid=%b len=%0d count=%0d required 1 56 0",
                     packet_valid, packet_byte_length, packet_count);
        end
        check_data("mid_new_pkt", 56);
        do_ack("mid_new_pkt");
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_oversize();
        test_keep_error();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time_ns=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
